// File: rtl/mandel_iter.sv
// Mandelbrot escape-time iterator: one z <- z^2 + c step per clock in signed fixed point (Q fractional bits).
// A pixel with final count n pulses done n+2 cycles after the start edge; start is ignored while busy.
module mandel_iter #(
  parameter int Q  = 15,
  parameter int N  = 32,
  parameter int IW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [N-1:0]  cr,
  input  logic [N-1:0]  ci,
  input  logic [IW-1:0] max_iter,
  output logic          busy,
  output logic          done,
  output logic [IW-1:0] iter_count,
  output logic          escaped
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // |z|^2 is compared against 4.0 expressed in the 2Q-fraction product scale
  localparam logic signed [2*N:0] ESC_LIM = {{(2*N-2*Q-2){1'b0}}, 3'b100, {(2*Q){1'b0}}};

  state_t r_state;
  state_t w_state_nxt;

  logic signed [N-1:0]   r_cr;
  logic signed [N-1:0]   r_ci;
  logic signed [N-1:0]   r_zr;
  logic signed [N-1:0]   r_zi;
  logic [IW-1:0]         r_max;
  logic [IW-1:0]         r_n;
  logic [IW-1:0]         r_iter_count;
  logic                  r_escaped;

  logic signed [2*N-1:0] w_zr_x;
  logic signed [2*N-1:0] w_zi_x;
  logic signed [2*N-1:0] w_p_rr;
  logic signed [2*N-1:0] w_p_ii;
  logic signed [2*N-1:0] w_p_ri;
  logic signed [2*N-1:0] w_diff;
  logic signed [2*N:0]   w_mag;
  logic                  w_escape;
  logic                  w_last;
  logic [N-1:0]          w_zr_nxt;
  logic [N-1:0]          w_zi_nxt;
  logic                  w_unused;

  assign w_zr_x = {{N{r_zr[N-1]}}, r_zr};
  assign w_zi_x = {{N{r_zi[N-1]}}, r_zi};

  assign w_p_rr = w_zr_x * w_zr_x;
  assign w_p_ii = w_zi_x * w_zi_x;
  assign w_p_ri = w_zr_x * w_zi_x;

  // one extra bit so the sum of two near-full-scale squares cannot overflow
  assign w_mag    = {w_p_rr[2*N-1], w_p_rr} + {w_p_ii[2*N-1], w_p_ii};
  assign w_escape = (w_mag > ESC_LIM);
  assign w_last   = w_escape || (r_n == r_max);

  // slicing the signed product drops low bits, i.e. floors toward -inf; the adds wrap
  assign w_diff   = w_p_rr - w_p_ii;
  assign w_zr_nxt = w_diff[N-1+Q:Q] + r_cr;
  assign w_zi_nxt = {w_p_ri[N-2+Q:Q], 1'b0} + r_ci;

  assign w_unused = ^{w_diff[2*N-1:N+Q], w_diff[Q-1:0],
                      w_p_ri[2*N-1:N-1+Q], w_p_ri[Q-1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_ITER;
      S_ITER:  if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      S_ITER: busy = 1'b1;
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cr         <= '0;
      r_ci         <= '0;
      r_max        <= '0;
      r_zr         <= '0;
      r_zi         <= '0;
      r_n          <= '0;
      r_iter_count <= '0;
      r_escaped    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cr  <= cr;
            r_ci  <= ci;
            r_max <= max_iter;
            r_zr  <= '0;
            r_zi  <= '0;
            r_n   <= '0;
          end
        end
        S_ITER: begin
          if (w_last) begin
            r_iter_count <= r_n;
            r_escaped    <= w_escape;
          end else begin
            r_zr <= w_zr_nxt;
            r_zi <= w_zi_nxt;
            r_n  <= r_n + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign iter_count = r_iter_count;
  assign escaped    = r_escaped;

endmodule

// File: tb/tb_mandel_iter.sv
// Bench for mandel_iter: directed spec vectors plus random pixels against an arithmetic escape-time model.
module tb_mandel_iter;

  localparam int Q  = 15;
  localparam int N  = 32;
  localparam int IW = 8;

  typedef logic signed [127:0] wide_t;

  logic          clk;
  logic          rst;
  logic          start;
  logic [N-1:0]  cr;
  logic [N-1:0]  ci;
  logic [IW-1:0] max_iter;
  logic          busy;
  logic          done;
  logic [IW-1:0] iter_count;
  logic          escaped;

  int n_tests = 0;
  int n_fail  = 0;

  int            g_lat;
  logic          g_to;
  logic [IW-1:0] g_cnt;
  logic          g_esc;
  logic          g_busy1;
  logic          g_busy_done;
  logic          g_busy_after;

  mandel_iter #(.Q(Q), .N(N), .IW(IW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cr         (cr),
    .ci         (ci),
    .max_iter   (max_iter),
    .busy       (busy),
    .done       (done),
    .iter_count (iter_count),
    .escaped    (escaped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic wide_t wrapn(input wide_t v);
    logic signed [N-1:0] t;
    t = v[N-1:0];
    return wide_t'(t);
  endfunction

  // escape-time reference: exact integers, floor on rescale, wrap to N bits after each add
  function automatic void model(input logic [N-1:0] a, input logic [N-1:0] b, input int mx,
                                output int cnt, output logic esc);
    wide_t zr, zi, car, cai, prr, pii, pri, lim;
    logic signed [N-1:0] sa, sb;
    sa  = a;
    sb  = b;
    car = wide_t'(sa);
    cai = wide_t'(sb);
    lim = wide_t'(4) <<< (2 * Q);
    zr  = 0;
    zi  = 0;
    cnt = 0;
    esc = 1'b0;
    for (int n = 0; n <= mx; n++) begin
      prr = zr * zr;
      pii = zi * zi;
      pri = zr * zi;
      cnt = n;
      if (prr + pii > lim) begin
        esc = 1'b1;
        return;
      end
      if (n == mx) return;
      zr = wrapn(((prr - pii) >>> Q) + car);
      zi = wrapn(((pri >>> Q) * 2) + cai);
    end
  endfunction

  function automatic logic [N-1:0] rnd_coord();
    if ($urandom_range(0, 7) == 0) return N'($urandom);
    return N'(int'($urandom_range(0, 163840)) - 81920);
  endfunction

  // called at a negedge; returns at the negedge after the DONE cycle
  task automatic run_pixel(input logic [N-1:0] a, input logic [N-1:0] b,
                           input logic [IW-1:0] m, input int noise);
    start    = 1'b1;
    cr       = a;
    ci       = b;
    max_iter = m;
    @(negedge clk);
    start   = 1'b0;
    g_lat   = 1;
    g_busy1 = busy;
    while (done !== 1'b1 && g_lat < 400) begin
      if (g_lat <= noise) begin
        start    = 1'b1;
        cr       = N'($urandom);
        ci       = N'($urandom);
        max_iter = IW'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      g_lat++;
    end
    g_to        = (done !== 1'b1);
    g_cnt       = iter_count;
    g_esc       = escaped;
    g_busy_done = busy;
    start       = (g_lat <= noise);
    @(negedge clk);
    start        = 1'b0;
    g_busy_after = busy;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; cr = '0; ci = '0; max_iter = '0;
    #1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_tests++; if (iter_count !== '0) begin n_fail++; $display("FAIL reset_iter_count: got %0d expected 0", iter_count); end
    n_tests++; if (escaped !== 1'b0) begin n_fail++; $display("FAIL reset_escaped: got %b expected 0", escaped); end
    start = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_start_ignored: busy got %b expected 0", busy); end
    start = 1'b0;
    rst   = 1'b0;
    @(negedge clk);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: busy got %b expected 0", busy); end
  endtask

  task automatic test_directed();
    logic [N-1:0]  t_cr  [4] = '{32'h0000_0000, 32'h0001_0000, 32'hFFFF_0000, 32'h0000_8000};
    logic [N-1:0]  t_ci  [4] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_8000};
    logic [IW-1:0] t_max [4] = '{8'd255, 8'd255, 8'd50, 8'd10};
    int            t_cnt [4] = '{255, 2, 50, 2};
    logic          t_esc [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 4; k++) begin
      run_pixel(t_cr[k], t_ci[k], t_max[k], 0);
      n_tests++; if (g_to !== 1'b0) begin n_fail++; $display("FAIL directed[%0d] timeout: done not seen within %0d cycles", k, g_lat); end
      n_tests++; if (int'(g_cnt) != t_cnt[k]) begin n_fail++; $display("FAIL directed[%0d] iter_count: got %0d expected %0d", k, g_cnt, t_cnt[k]); end
      n_tests++; if (g_esc !== t_esc[k]) begin n_fail++; $display("FAIL directed[%0d] escaped: got %b expected %b", k, g_esc, t_esc[k]); end
      n_tests++; if (g_lat != t_cnt[k] + 2) begin n_fail++; $display("FAIL directed[%0d] latency: got %0d expected %0d", k, g_lat, t_cnt[k] + 2); end
      n_tests++; if (g_busy_after !== 1'b0) begin n_fail++; $display("FAIL directed[%0d] busy_after_done: got %b expected 0", k, g_busy_after); end
    end
  endtask

  task automatic test_max_iter_zero();
    run_pixel(32'h0001_0000, 32'h0000_0000, 8'd0, 3);
    n_tests++; if (g_lat != 2) begin n_fail++; $display("FAIL max0 latency: got %0d expected 2", g_lat); end
    n_tests++; if (g_cnt !== 8'd0) begin n_fail++; $display("FAIL max0 iter_count: got %0d expected 0", g_cnt); end
    n_tests++; if (g_esc !== 1'b0) begin n_fail++; $display("FAIL max0 escaped: got %b expected 0", g_esc); end
    n_tests++; if (g_busy_after !== 1'b0) begin n_fail++; $display("FAIL max0 start_in_done_ignored: busy got %b expected 0", g_busy_after); end
    // inputs scrambled with start held for most of the run must not disturb the latched pixel
    run_pixel(32'h0000_0000, 32'h0000_0000, 8'd20, 15);
    n_tests++; if (g_cnt !== 8'd20) begin n_fail++; $display("FAIL busy_start_ignored iter_count: got %0d expected 20", g_cnt); end
    n_tests++; if (g_esc !== 1'b0) begin n_fail++; $display("FAIL busy_start_ignored escaped: got %b expected 0", g_esc); end
    n_tests++; if (g_lat != 22) begin n_fail++; $display("FAIL busy_start_ignored latency: got %0d expected 22", g_lat); end
  endtask

  task automatic test_random(input int count, input string tag);
    logic [N-1:0]  a, b;
    logic [IW-1:0] m;
    int            ec;
    logic          ee;
    for (int k = 0; k < count; k++) begin
      a = rnd_coord();
      b = rnd_coord();
      m = IW'($urandom_range(0, 60));
      model(a, b, int'(m), ec, ee);
      run_pixel(a, b, m, $urandom_range(0, 3));
      n_tests++; if (g_to !== 1'b0) begin n_fail++; $display("FAIL %s[%0d] timeout: done not seen within %0d cycles", tag, k, g_lat); end
      n_tests++; if (int'(g_cnt) != ec) begin n_fail++; $display("FAIL %s[%0d] iter_count: got %0d expected %0d (cr=%h ci=%h max=%0d)", tag, k, g_cnt, ec, a, b, m); end
      n_tests++; if (g_esc !== ee) begin n_fail++; $display("FAIL %s[%0d] escaped: got %b expected %b (cr=%h ci=%h max=%0d)", tag, k, g_esc, ee, a, b, m); end
      n_tests++; if (g_lat != ec + 2) begin n_fail++; $display("FAIL %s[%0d] latency: got %0d expected %0d", tag, k, g_lat, ec + 2); end
      n_tests++; if (g_busy1 !== 1'b1) begin n_fail++; $display("FAIL %s[%0d] busy_first_cycle: got %b expected 1", tag, k, g_busy1); end
      n_tests++; if (g_busy_done !== 1'b1) begin n_fail++; $display("FAIL %s[%0d] busy_in_done: got %b expected 1", tag, k, g_busy_done); end
      n_tests++; if (g_busy_after !== 1'b0) begin n_fail++; $display("FAIL %s[%0d] busy_after_done: got %b expected 0", tag, k, g_busy_after); end
    end
  endtask

  task automatic test_back_to_back();
    test_random(12, "back_to_back");
  endtask

  task automatic test_rst_mid();
    logic seen;
    run_pixel(32'h0001_0000, 32'h0000_0000, 8'd255, 0);
    n_tests++; if (g_cnt !== 8'd2 || g_esc !== 1'b1) begin n_fail++; $display("FAIL rst_pre_result: got cnt=%0d esc=%b expected cnt=2 esc=1", g_cnt, g_esc); end
    start = 1'b1; cr = '0; ci = '0; max_iter = 8'd200;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_mid_busy_before: got %b expected 1", busy); end
    #2 rst = 1'b1;
    #1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_async_busy: got %b expected 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_async_done: got %b expected 0", done); end
    n_tests++; if (iter_count !== '0) begin n_fail++; $display("FAIL rst_async_iter_count: got %0d expected 0", iter_count); end
    n_tests++; if (escaped !== 1'b0) begin n_fail++; $display("FAIL rst_async_escaped: got %b expected 0", escaped); end
    start = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_start_ignored: busy got %b expected 0", busy); end
    rst   = 1'b0;
    start = 1'b0;
    seen  = 1'b0;
    repeat (250) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rst_no_done_after_abort: activity got %b expected 0", seen); end
    run_pixel(32'h0000_8000, 32'h0000_8000, 8'd10, 0);
    n_tests++; if (g_cnt !== 8'd2) begin n_fail++; $display("FAIL post_rst_iter_count: got %0d expected 2", g_cnt); end
    n_tests++; if (g_esc !== 1'b1) begin n_fail++; $display("FAIL post_rst_escaped: got %b expected 1", g_esc); end
    n_tests++; if (g_lat != 4) begin n_fail++; $display("FAIL post_rst_latency: got %0d expected 4", g_lat); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_max_iter_zero();
    test_random(40, "random");
    test_back_to_back();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mandel_iter.md
MANDEL_ITER -- requirements
Module: mandel_iter

Interface
REQ-001 The module SHALL have parameter Q, default 15, meaning the number of fractional bits of the two's-complement fixed-point format.
REQ-002 The module SHALL have parameter N, default 32, meaning the total fixed-point word width including sign.
REQ-003 The module SHALL have parameter IW, default 8, meaning the iteration counter width.
REQ-004 The module SHALL have port clk  input  1  system clock; all state updates occur on its rising edge.
REQ-005 The module SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 The module SHALL have port start  input  1  request to begin one pixel computation.
REQ-007 The module SHALL have port cr  input  N  real part of c, signed Qm.Q.
REQ-008 The module SHALL have port ci  input  N  imaginary part of c, signed Qm.Q.
REQ-009 The module SHALL have port max_iter  input  IW  iteration limit.
REQ-010 The module SHALL have port busy  output  1  high while a computation is in progress.
REQ-011 The module SHALL have port done  output  1  one-cycle completion pulse.
REQ-012 The module SHALL have port iter_count  output  IW  final iteration index.
REQ-013 The module SHALL have port escaped  output  1  high if the point diverged before max_iter.

Function
REQ-014 The FSM SHALL have exactly the states IDLE, ITER and DONE.
REQ-015 In IDLE, start=1 at a rising edge SHALL latch cr, ci and max_iter, clear zr, zi and n to 0, and enter ITER; busy SHALL go high on that edge.
REQ-016 start SHALL be ignored in ITER and DONE; latched cr, ci and max_iter SHALL NOT change mid-computation.
REQ-017 Each ITER cycle SHALL form the full 2N-bit signed products P_rr=zr*zr, P_ii=zi*zi and P_ri=zr*zi.
REQ-018 The escape condition SHALL be (P_rr + P_ii) > (4 << 2Q), evaluated at 2N+1 bits with no overflow; the value 4.0 exactly SHALL NOT escape.
REQ-019 Each ITER cycle, if escape is true or n == max_iter, the FSM SHALL enter DONE, load iter_count with n and escaped with the escape condition, and leave z unchanged.
REQ-020 Otherwise the ITER cycle SHALL update zr to (P_rr - P_ii)[N-1+Q:Q] + cr, zi to (P_ri[N-1+Q:Q] << 1) + ci, and n to n+1.
REQ-021 The slice [N-1+Q:Q] SHALL be arithmetic truncation toward negative infinity, with no rounding.
REQ-022 All N-bit additions and subtractions SHALL wrap modulo 2^N, with no saturation, matching the team fixed-point adder.
REQ-023 If the escape condition and n == max_iter are true in the same cycle, escaped SHALL be 1.
REQ-024 In DONE, done SHALL be 1 for exactly one cycle and busy SHALL be 1, then the FSM SHALL return to IDLE with busy=0.
REQ-025 For a final count n, done SHALL be high in the (n+2)th cycle after the start edge; throughput SHALL be one iteration per clock.
REQ-026 iter_count and escaped SHALL hold their values from the DONE entry until the next DONE entry or reset.
REQ-027 max_iter=0 SHALL complete after one ITER cycle with iter_count=0 and escaped=0.

Reset
REQ-028 While rst=1, the FSM SHALL be in IDLE and busy, done, escaped, iter_count, zr, zi and n SHALL all be 0, independent of clk.
REQ-029 Asserting rst during ITER or DONE SHALL abort the computation without producing a done pulse; start SHALL NOT be honoured while rst=1.
REQ-030 After rst deasserts, the first rising edge with start=1 SHALL begin a new computation normally.

Verification
REQ-031 cr=0, ci=0, max_iter=255 -> done with iter_count=255, escaped=0.
REQ-032 cr=0x00010000 (2.0), ci=0, max_iter=255 -> iter_count=2, escaped=1 (|z1|^2=4.0 does not escape; z2=6.0 does).
REQ-033 cr=0xFFFF0000 (-2.0), ci=0, max_iter=50 -> z sticks at 2.0 with |z|^2=4.0 boundary, giving iter_count=50, escaped=0.
REQ-034 cr=ci=0x00008000 (1+1i), max_iter=10 -> z1=(1,1), z2=(1,3), giving iter_count=2, escaped=1, done exactly 4 cycles after the start edge.
REQ-035 max_iter=0 -> done in the 2nd cycle after start with iter_count=0; a start pulse while busy is ignored.
REQ-036 rst pulsed mid-ITER with cr=0 -> busy=0, done never asserted, and outputs return to 0 asynchronously.
